// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0]        addr;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;

    // Signed word offset turned into a byte displacement.
    function automatic logic [31:0] branch_disp(input logic [15:0] offset);
        return {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/Adder.sv
// Generic ripple adder with carry in/out, shared across the datapath.
module Adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching a word that arrives while IF/ID is stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output logic         full,
    output fetch_entry_t entry
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload has no reset; it is only read while full is set.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            entry <= load_entry;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, IF/ID register
// backed by a skid buffer, and branch redirect that drops in-flight data.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_pc,
    input  logic [15:0]        br_offset,
    fetch_ctrl_if.master       imem,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_addr;
    logic         req_q;

    logic [31:0]  pc_plus4;
    logic [31:0]  br_target;
    logic         pc4_cout_unused;
    logic         tgt_cout_unused;

    logic         transfer;
    logic         ifid_free;
    logic         req_pending;

    logic         skid_load;
    logic         skid_unload;
    logic         skid_full;
    fetch_entry_t skid_in;
    fetch_entry_t skid_out;

    Adder #(.WIDTH(32)) u_pc_inc (
        .a    (fetch_pc),
        .b    (32'd4),
        .cin  (1'b0),
        .sum  (pc_plus4),
        .cout (pc4_cout_unused)
    );

    Adder #(.WIDTH(32)) u_br_tgt (
        .a    (br_pc),
        .b    (branch_disp(br_offset)),
        .cin  (1'b0),
        .sum  (br_target),
        .cout (tgt_cout_unused)
    );

    assign transfer  = req_q & imem.imem_ack;
    assign ifid_free = ~valid | ~stall;
    // A redirect may only leave REQ/DROP immediately if nothing is left in flight.
    assign req_pending = ((state == REQ) || (state == DROP)) && !transfer;

    assign skid_in     = '{addr: fetch_pc, data: imem.imem_rdata};
    assign skid_load   = (state == REQ) && transfer && !ifid_free && !br_taken;
    assign skid_unload = (state == HOLD) && skid_full && !stall && !br_taken;

    fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (br_taken),
        .load_entry (skid_in),
        .full       (skid_full),
        .entry      (skid_out)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr;

    // NOTE: all state below uses non-blocking assignments so every branch sees
    // the pre-edge values of fetch_pc, valid and state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            req_q    <= 1'b0;
            pc       <= 32'h0000_0000;
            instr    <= NOP;
            valid    <= 1'b0;
        end else if (br_taken) begin
            fetch_pc <= br_target;
            valid    <= 1'b0;
            req_q    <= 1'b1;
            if (req_pending) begin
                state <= DROP;
            end else begin
                state    <= REQ;
                req_addr <= br_target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    req_q    <= 1'b1;
                    req_addr <= fetch_pc;
                end
                REQ: begin
                    if (transfer && ifid_free) begin
                        pc       <= fetch_pc;
                        instr    <= imem.imem_rdata;
                        valid    <= 1'b1;
                        fetch_pc <= pc_plus4;
                        req_addr <= pc_plus4;
                    end else if (skid_load) begin
                        state <= HOLD;
                        req_q <= 1'b0;
                    end else if (!stall) begin
                        valid <= 1'b0;
                    end
                end
                DROP: begin
                    // The old word is thrown away; fetch_pc already holds the target.
                    if (transfer) begin
                        state    <= REQ;
                        req_addr <= fetch_pc;
                    end
                end
                HOLD: begin
                    if (skid_unload) begin
                        pc       <= skid_out.addr;
                        instr    <= skid_out.data;
                        valid    <= 1'b1;
                        fetch_pc <= pc_plus4;
                        req_addr <= pc_plus4;
                        req_q    <= 1'b1;
                        state    <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized checks of fetch_ctrl against a transaction-order model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [15:0] br_offset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        ack;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign bus.imem_ack   = ack;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .imem      (bus),
        .pc        (pc),
        .instr     (instr),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_pc     = 32'h0;
        br_offset = 16'h0;
        ack       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(bus.imem_req), 32'd0);
        check({tag, "_addr"},  bus.imem_addr, RESET_PC);
        check({tag, "_pc"},    pc, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    task automatic run_to_addr(input logic [31:0] a);
        int n = 0;
        while (!(bus.imem_req && bus.imem_addr == a) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("reach_addr", bus.imem_addr, a);
        check("reach_req", 32'(bus.imem_req), 32'd1);
    endtask

    logic [31:0] pc_before;
    logic [31:0] exp_pc;
    logic [31:0] prev_addr, prev_pc, prev_instr;
    logic        prev_pending, prev_br, prev_valid, prev_stall;
    logic [31:0] r;
    int          since;

    initial begin
        // Reset values, then zero-wait streaming.
        do_reset();
        ack = 1'b1;
        @(negedge clk);
        check_reset_values("rst");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stream_req", 32'(bus.imem_req), 32'd1);
            check("stream_addr", bus.imem_addr, RESET_PC + 32'(4 * k));
            check("stream_valid", 32'(valid), 32'(k > 0));
            if (k > 0) check("stream_pc", pc, RESET_PC + 32'(4 * (k - 1)));
        end

        // Ack held off for three cycles at 0x10.
        @(negedge clk);
        check("dly_addr0", bus.imem_addr, 32'h10);
        check("dly_pc0", pc, 32'hC);
        ack = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("dly_addr", bus.imem_addr, 32'h10);
            check("dly_req", 32'(bus.imem_req), 32'd1);
            check("dly_valid", 32'(valid), 32'd0);
            if (k == 3) ack = 1'b1;
        end
        @(negedge clk);
        check("dly_pc", pc, 32'h10);
        check("dly_valid1", 32'(valid), 32'd1);
        check("dly_instr", instr, mem_word(32'h10));
        check("dly_next", bus.imem_addr, 32'h14);

        // Four-cycle stall while IF/ID holds 0x20.
        run_to_addr(32'h24);
        check("stl_pc0", pc, 32'h20);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stl_req", 32'(bus.imem_req), 32'd0);
            check("stl_pc", pc, 32'h20);
            check("stl_valid", 32'(valid), 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stl_rel_pc", pc, 32'h24);
        check("stl_rel_instr", instr, mem_word(32'h24));
        check("stl_rel_valid", 32'(valid), 32'd1);
        check("stl_rel_addr", bus.imem_addr, 32'h28);
        @(negedge clk);
        check("stl_after_pc", pc, 32'h28);

        // Redirect during an outstanding request to 0x40.
        run_to_addr(32'h40);
        ack = 1'b0; br_taken = 1'b1; br_pc = 32'h104; br_offset = 16'hFFFF;
        @(negedge clk);
        br_taken = 1'b0;
        check("drop_req", 32'(bus.imem_req), 32'd1);
        check("drop_addr", bus.imem_addr, 32'h40);
        check("drop_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("drop_addr2", bus.imem_addr, 32'h40);
        check("drop_valid2", 32'(valid), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        check("tgt_addr", bus.imem_addr, 32'h100);
        check("tgt_req", 32'(bus.imem_req), 32'd1);
        check("tgt_valid", 32'(valid), 32'd0);
        ack = 1'b0;
        @(negedge clk);
        check("tgt_addr2", bus.imem_addr, 32'h100);
        check("tgt_valid2", 32'(valid), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        check("tgt_pc", pc, 32'h100);
        check("tgt_instr", instr, mem_word(32'h100));
        check("tgt_valid3", 32'(valid), 32'd1);

        // Branch, stall and ack all in one cycle.
        pc_before = pc;
        stall = 1'b1; br_taken = 1'b1; br_pc = 32'h200; br_offset = 16'h0004;
        @(negedge clk);
        stall = 1'b0; br_taken = 1'b0;
        check("bsa_valid", 32'(valid), 32'd0);
        check("bsa_pc_kept", pc, pc_before);
        check("bsa_addr", bus.imem_addr, 32'h210);
        @(negedge clk);
        check("bsa_pc", pc, 32'h210);
        check("bsa_instr", instr, mem_word(32'h210));

        // Second redirect while dropping; target wraps past 2^32.
        ack = 1'b0; br_taken = 1'b1; br_pc = 32'h300; br_offset = 16'h0000;
        @(negedge clk);
        check("dd_addr", bus.imem_addr, 32'h214);
        check("dd_req", 32'(bus.imem_req), 32'd1);
        br_taken = 1'b1; br_pc = 32'hFFFF_FFFC; br_offset = 16'h0002;
        @(negedge clk);
        br_taken = 1'b0;
        check("dd_addr2", bus.imem_addr, 32'h214);
        check("dd_valid", 32'(valid), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        check("wrap_addr", bus.imem_addr, 32'h4);
        check("wrap_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("wrap_pc", pc, 32'h4);
        check("wrap_valid1", 32'(valid), 32'd1);

        // Reset in the middle of a request; the stale ack must be ignored.
        ack = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_values("rst_mid");
        ack = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rm_idle_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("rm_first_req", 32'(bus.imem_req), 32'd1);
        check("rm_first_addr", bus.imem_addr, RESET_PC);
        @(negedge clk);
        check("rm_pc", pc, RESET_PC);
        check("rm_valid", 32'(valid), 32'd1);
        check("rm_instr", instr, mem_word(RESET_PC));

        // Reset while the skid buffer holds a word.
        stall = 1'b1;
        @(negedge clk);
        check("rh_hold_req", 32'(bus.imem_req), 32'd0);
        #2 rst = 1'b0;
        #1 check_reset_values("rst_hold");
        stall = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rh_idle_req", 32'(bus.imem_req), 32'd0);
        check("rh_idle_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("rh_first_addr", bus.imem_addr, RESET_PC);
        check("rh_first_req", 32'(bus.imem_req), 32'd1);
        @(negedge clk);
        check("rh_pc", pc, RESET_PC);
        check("rh_next_addr", bus.imem_addr, RESET_PC + 32'd4);

        // Random traffic against an in-order delivery model.
        do_reset();
        exp_pc       = RESET_PC;
        prev_pending = 1'b0;
        prev_br      = 1'b0;
        prev_valid   = 1'b0;
        prev_stall   = 1'b0;
        prev_addr    = 32'h0;
        prev_pc      = 32'h0;
        prev_instr   = 32'h0;
        since        = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_pending) begin
                check("rnd_hold_req", 32'(bus.imem_req), 32'd1);
                check("rnd_hold_addr", bus.imem_addr, prev_addr);
            end
            if (prev_br) begin
                check("rnd_flush", 32'(valid), 32'd0);
            end else if (prev_valid && prev_stall) begin
                check("rnd_stall_valid", 32'(valid), 32'd1);
                check("rnd_stall_pc", pc, prev_pc);
                check("rnd_stall_instr", instr, prev_instr);
            end
            if (valid) begin
                check("rnd_pc", pc, exp_pc);
                check("rnd_instr", instr, mem_word(pc));
            end

            stall    = ($urandom_range(3) == 0);
            ack      = ($urandom_range(2) != 0);
            br_taken = ($urandom_range(15) == 0);
            r        = $urandom();
            br_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + {28'h0, r[3:2], 2'b00})
                                                : {r[31:2], 2'b00};
            r         = $urandom();
            br_offset = r[15:0];

            prev_pending = bus.imem_req && !ack;
            prev_addr    = bus.imem_addr;
            prev_br      = br_taken;
            prev_valid   = valid;
            prev_stall   = stall;
            prev_pc      = pc;
            prev_instr   = instr;

            if (br_taken) begin
                exp_pc = br_pc + 32'($signed(br_offset)) * 32'd4;
                since  = 0;
            end else if (valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
                since  = 0;
            end else begin
                since++;
            end
            if (since > 64) begin
                check("rnd_progress", 32'(since), 32'd0);
                break;
            end
        end
        br_taken = 1'b0;
        stall    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  decode cannot accept; hold the IF/ID outputs.
REQ-005 br_taken  input  1  branch redirect request, single-cycle pulse.
REQ-006 br_pc  input  32  PC+4 of the branch instruction.
REQ-007 br_offset  input  16  signed word offset.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0.
REQ-010 imem_ack  input  1  transfer completes on a cycle with imem_req=1 and imem_ack=1; may be combinational.
REQ-011 imem_rdata  input  32  instruction word; valid on the transfer cycle.
REQ-012 pc  output  32  address of the instruction in IF/ID.
REQ-013 instr  output  32  IF/ID instruction.
REQ-014 valid  output  1  IF/ID holds a live instruction.

Function
REQ-015 FSM states: IDLE, REQ, DROP, HOLD; at most one request outstanding at any time.
REQ-016 IDLE: imem_req=0; always moves to REQ after one cycle.
REQ-017 REQ: imem_req=1, imem_addr=fetch_pc.
REQ-018 REQ transfer, IF/ID free (valid=0 or stall=0): IF/ID gets {fetch_pc, imem_rdata, valid=1}; fetch_pc += 4 modulo 2^32; stay in REQ. Zero-wait memory sustains one instruction per cycle.
REQ-019 REQ transfer, IF/ID occupied and stall=1: word and address go to a one-entry skid buffer; state goes to HOLD with imem_req=0.
REQ-020 HOLD, stall=0: skid contents move into IF/ID with valid=1; fetch_pc += 4; state goes to REQ.
REQ-021 Branch target = br_pc + (sign_extend(br_offset) << 2), modulo 2^32.
REQ-022 br_taken=1 redirect: fetch_pc <= target; IF/ID valid <= 0 (flush); skid buffer discarded.
REQ-023 Redirect next state: REQ if no request is pending or the pending request completes in the same cycle; otherwise DROP.
REQ-024 DROP: imem_req stays high at the old address; on transfer, data is discarded and state goes to REQ at target.
REQ-025 br_taken while already in DROP: target is updated; state stays DROP.
REQ-026 br_taken beats stall and transfer in the same cycle; the transferred word is never written to IF/ID.
REQ-027 stall with valid=0 does not block loading IF/ID.
REQ-028 IF/ID pc and instr change only when valid is being set or IF/ID is being loaded.

Reset
REQ-029 Asynchronous reset takes effect immediately, mid-operation included: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, pc=0, instr=0, valid=0, skid buffer empty.
REQ-030 An imem_ack or response belonging to a request that reset aborted is ignored; the memory tolerates a dropped request.
REQ-031 The first request is issued in the second cycle after rst deasserts.

Structure
REQ-032 Shared package fetch_pkg holds: FSM state enumeration, default RESET_PC, NOP constant 32'h0000_0000, INSTR_W=32.
REQ-033 One sub-module, fetch_skid: one-entry buffer {addr, data, full} with load/unload/clear.
REQ-034 PC+4 and target arithmetic reuse the existing Adder module with 32-bit width; carry-out is ignored.

Verification
REQ-035 Zero-wait memory (ack tied 1), no stall/branch, RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles; pc lags by one cycle; valid=1 from the third post-reset cycle.
REQ-036 ack delayed 3 cycles on addr 0x10 -> imem_addr held at 0x10 for all 4 cycles; valid=0 until capture; then pc=0x10.
REQ-037 stall=1 for 4 cycles while IF/ID holds 0x20 -> one extra word (0x24) captured to skid; imem_req=0 in HOLD. On stall release, pc=0x24 next cycle; no instruction lost or duplicated.
REQ-038 br_taken with br_pc=0x104 and br_offset=16'hFFFF during an outstanding request to 0x40 -> DROP, 0x40 data discarded, next request to 0x100, valid=0 until 0x100 returns.
REQ-039 br_taken, stall and ack in the same cycle -> valid=0 next cycle; fetch at target.
REQ-040 Reset asserted mid-request and in HOLD -> all outputs at reset values the same cycle; first request to RESET_PC two cycles after release.
